// File: rtl/mem_ahb_dpram_ctrl.sv
// AHB-Lite slave front end for mem_ahb_dpram_sync: maps AHB beats onto the RAM write/read ports,
// builds byte strobes, inserts one wait state on read-after-write to the same word, errors bad sizes.
module mem_ahb_dpram_ctrl #(
  parameter int unsigned WIDTH_AD  = 10,
  parameter int unsigned WIDTH_DA  = 32,
  parameter int unsigned WIDTH_DS  = WIDTH_DA / 8,
  parameter int unsigned WIDTH_DSB = $clog2(WIDTH_DS)
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                HSEL,
  input  logic [31:0]         HADDR,
  input  logic [1:0]          HTRANS,
  input  logic                HWRITE,
  input  logic [2:0]          HSIZE,
  input  logic [2:0]          HBURST,
  input  logic [WIDTH_DA-1:0] HWDATA,
  input  logic                HREADY,
  output logic                HREADYOUT,
  output logic                HRESP,
  output logic [WIDTH_DA-1:0] HRDATA,
  output logic [WIDTH_AD-1:0] WADDR,
  output logic [WIDTH_DA-1:0] WDATA,
  output logic [WIDTH_DS-1:0] WSTRB,
  output logic                WEN,
  output logic [WIDTH_AD-1:0] RADDR,
  output logic [WIDTH_DS-1:0] RSTRB,
  output logic                REN,
  input  logic [WIDTH_DA-1:0] RDATA
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WR    = 3'd1;
  localparam logic [2:0] ST_RD    = 3'd2;
  localparam logic [2:0] ST_STALL = 3'd3;
  localparam logic [2:0] ST_ERR1  = 3'd4;
  localparam logic [2:0] ST_ERR2  = 3'd5;

  logic [2:0]          state_q, state_d;
  logic [WIDTH_AD-1:0] addr_q, addr_d;
  logic [WIDTH_DS-1:0] strb_q, strb_d;

  logic [WIDTH_AD-1:0] haddr_ram;
  logic [WIDTH_DS:0]   span;
  logic [WIDTH_DS-1:0] strb;
  logic                accept;
  logic                bad_size;
  logic                hazard;
  logic                unused_ok;

  always_comb begin
    haddr_ram = HADDR[WIDTH_AD-1:0];
    unused_ok = ^{HBURST, HADDR[31:WIDTH_AD]};
    // span = 2^HSIZE low ones; one extra bit so a full-width beat does not overflow
    span      = ({{WIDTH_DS{1'b0}}, 1'b1} << (32'd1 << HSIZE)) - {{WIDTH_DS{1'b0}}, 1'b1};
    strb      = span[WIDTH_DS-1:0] << HADDR[WIDTH_DSB-1:0];
    bad_size  = HSIZE > 3'(WIDTH_DSB);
    accept    = HSEL && HREADY && HTRANS[1] && !RESET;
    hazard    = (state_q == ST_WR) && !HWRITE &&
                (haddr_ram[WIDTH_AD-1:WIDTH_DSB] == addr_q[WIDTH_AD-1:WIDTH_DSB]);
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    strb_d  = strb_q;
    case (state_q)
      ST_STALL: state_d = ST_RD;
      ST_ERR1:  state_d = ST_ERR2;
      default: begin
        state_d = ST_IDLE;
        if (accept) begin
          if (bad_size) begin
            state_d = ST_ERR1;
          end else begin
            // a read accepted during WR replaces the write address; the write uses addr_q this cycle
            addr_d = haddr_ram;
            strb_d = strb;
            if (HWRITE)      state_d = ST_WR;
            else if (hazard) state_d = ST_STALL;
            else             state_d = ST_RD;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      strb_q  <= strb_d;
    end
  end

  always_comb begin
    HREADYOUT = !((state_q == ST_STALL) || (state_q == ST_ERR1));
    HRESP     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
    HRDATA    = (state_q == ST_RD) ? RDATA : '0;
    WEN       = (state_q == ST_WR) && !RESET;
    WADDR     = addr_q;
    WSTRB     = strb_q;
    WDATA     = HWDATA;
    if (state_q == ST_STALL) begin
      REN   = !RESET;
      RADDR = addr_q;
      RSTRB = strb_q;
    end else begin
      REN   = accept && !HWRITE && !bad_size;
      RADDR = haddr_ram;
      RSTRB = strb;
    end
  end

endmodule

// File: tb/tb_mem_ahb_dpram_ctrl.sv
// Bench for mem_ahb_dpram_ctrl: pipelined AHB master over a vector table with a RAM model,
// plus hand-written reset-during-transfer sequences.
module tb_mem_ahb_dpram_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;
  logic [9:0]  waddr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wen;
  logic [9:0]  raddr;
  logic [3:0]  rstrb;
  logic        ren;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  // single-slave interconnect: bus ready follows the slave
  assign hready = hreadyout;

  mem_ahb_dpram_ctrl #(.WIDTH_AD(10), .WIDTH_DA(32)) dut (
    .CLK(clk), .RESET(reset), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(hready),
    .HREADYOUT(hreadyout), .HRESP(hresp), .HRDATA(hrdata),
    .WADDR(waddr), .WDATA(wdata), .WSTRB(wstrb), .WEN(wen),
    .RADDR(raddr), .RSTRB(rstrb), .REN(ren), .RDATA(rdata)
  );

  logic [31:0] mem [0:255];

  always @(posedge clk) begin
    if (wen)
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) mem[waddr[9:2]][8*b +: 8] <= wdata[8*b +: 8];
    if (ren) rdata <= mem[raddr[9:2]];
  end

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [1:0]  trans;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_strb;
    int          exp_waits;
    bit          exp_err;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk_w(logic [31:0] a, logic [2:0] s, logic [31:0] d, logic [3:0] st,
                                logic [1:0] t);
    vec_t v;
    v = '{wr: 1'b1, addr: a, size: s, trans: t, wdata: d, exp_rdata: '0, exp_strb: st,
          exp_waits: 0, exp_err: 1'b0};
    return v;
  endfunction

  function automatic vec_t mk_r(logic [31:0] a, logic [2:0] s, logic [31:0] e, int w,
                                logic [1:0] t);
    vec_t v;
    v = '{wr: 1'b0, addr: a, size: s, trans: t, wdata: '0, exp_rdata: e, exp_strb: '0,
          exp_waits: w, exp_err: 1'b0};
    return v;
  endfunction

  function automatic vec_t mk_e(logic [31:0] a, logic [2:0] s);
    vec_t v;
    v = '{wr: 1'b1, addr: a, size: s, trans: 2'b10, wdata: 32'hFFFF_FFFF, exp_rdata: '0,
          exp_strb: '0, exp_waits: 1, exp_err: 1'b1};
    return v;
  endfunction

  function automatic vec_t mk_i(logic [1:0] t, logic [31:0] a, logic [31:0] d);
    vec_t v;
    v = '{wr: 1'b1, addr: a, size: 3'd2, trans: t, wdata: d, exp_rdata: '0, exp_strb: '0,
          exp_waits: 0, exp_err: 1'b0};
    return v;
  endfunction

  task automatic drive_ap(input vec_t v);
    hsel   = 1'b1;
    haddr  = v.addr;
    hwrite = v.wr;
    hsize  = v.size;
    htrans = v.trans;
  endtask

  task automatic drive_idle();
    hsel   = 1'b1;
    htrans = 2'b00;
    hwrite = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t cur;
    vec_t op;
    bit   ap_valid;
    bit   dp_valid;
    bit   last_hready;
    int   waits;
    int   guard;
    int unsigned idx;

    for (int i = 0; i < 256; i++) mem[i] = '0;
    rdata  = '0;
    hburst = 3'b001;
    hwdata = 32'hFFFF_FFFF;

    // reset held 3 cycles with a NONSEQ write on the bus
    reset = 1'b1;
    op = mk_w(32'h100, 3'd2, 32'hFFFF_FFFF, 4'hF, 2'b10);
    drive_ap(op);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst_hreadyout", 32'(hreadyout), 32'd1);
      chk("rst_hresp", 32'(hresp), 32'd0);
      chk("rst_wen_ren", {30'b0, wen, ren}, 32'd0);
      chk("rst_hrdata", hrdata, 32'd0);
    end
    reset = 1'b0;
    drive_idle();
    step();
    chk("rst_no_ram_change", mem[8'h40], 32'd0);

    tbl.push_back(mk_w(32'h10, 3'd2, 32'hDEAD_BEEF, 4'b1111, 2'b10));
    tbl.push_back(mk_r(32'h20, 3'd2, 32'h0, 0, 2'b10));
    tbl.push_back(mk_i(2'b00, 32'h0, 32'h0));
    tbl.push_back(mk_r(32'h10, 3'd2, 32'hDEAD_BEEF, 0, 2'b10));
    tbl.push_back(mk_w(32'h13, 3'd0, 32'hAA00_0000, 4'b1000, 2'b10));
    tbl.push_back(mk_w(32'h10, 3'd1, 32'h0000_5566, 4'b0011, 2'b10));
    tbl.push_back(mk_i(2'b00, 32'h0, 32'h0));
    tbl.push_back(mk_r(32'h10, 3'd2, 32'hAAAD_5566, 0, 2'b10));
    tbl.push_back(mk_w(32'h40, 3'd2, 32'h1234_5678, 4'b1111, 2'b10));
    tbl.push_back(mk_r(32'h42, 3'd1, 32'h1234_5678, 1, 2'b10));
    tbl.push_back(mk_w(32'h12, 3'd0, 32'h0077_0000, 4'b0100, 2'b10));
    tbl.push_back(mk_w(32'h22, 3'd1, 32'h9988_0000, 4'b1100, 2'b10));
    tbl.push_back(mk_r(32'h20, 3'd2, 32'h9988_0000, 1, 2'b10));
    tbl.push_back(mk_r(32'h10, 3'd2, 32'hAA77_5566, 0, 2'b10));
    tbl.push_back(mk_e(32'h44, 3'd3));
    tbl.push_back(mk_i(2'b00, 32'h0, 32'h0));
    tbl.push_back(mk_r(32'h40, 3'd2, 32'h1234_5678, 0, 2'b10));
    tbl.push_back(mk_w(32'h80, 3'd2, 32'h1111_1111, 4'b1111, 2'b10));
    tbl.push_back(mk_r(32'h84, 3'd2, 32'h0, 0, 2'b11));
    tbl.push_back(mk_w(32'h88, 3'd2, 32'h2222_2222, 4'b1111, 2'b11));
    tbl.push_back(mk_r(32'h88, 3'd2, 32'h2222_2222, 1, 2'b11));
    tbl.push_back(mk_w(32'h8C, 3'd2, 32'h3333_3333, 4'b1111, 2'b11));
    tbl.push_back(mk_r(32'h80, 3'd2, 32'h1111_1111, 0, 2'b11));
    tbl.push_back(mk_w(32'h84, 3'd2, 32'h4444_4444, 4'b1111, 2'b11));
    tbl.push_back(mk_r(32'h84, 3'd2, 32'h4444_4444, 1, 2'b11));
    tbl.push_back(mk_w(32'h90, 3'd2, 32'h5555_5555, 4'b1111, 2'b11));
    tbl.push_back(mk_r(32'h8C, 3'd2, 32'h3333_3333, 0, 2'b11));
    tbl.push_back(mk_w(32'h80, 3'd2, 32'h6666_6666, 4'b1111, 2'b11));
    tbl.push_back(mk_r(32'h80, 3'd2, 32'h6666_6666, 1, 2'b11));
    tbl.push_back(mk_w(32'h94, 3'd2, 32'h7777_7777, 4'b1111, 2'b11));
    tbl.push_back(mk_r(32'h90, 3'd2, 32'h5555_5555, 0, 2'b11));
    tbl.push_back(mk_w(32'h98, 3'd2, 32'h8888_8888, 4'b1111, 2'b11));
    tbl.push_back(mk_r(32'h98, 3'd2, 32'h8888_8888, 1, 2'b11));
    tbl.push_back(mk_i(2'b00, 32'h0, 32'h0));
    tbl.push_back(mk_w(32'h7FC, 3'd2, 32'hCAFE_F00D, 4'b1111, 2'b10));
    tbl.push_back(mk_i(2'b00, 32'h0, 32'h0));
    tbl.push_back(mk_r(32'h3FC, 3'd2, 32'hCAFE_F00D, 0, 2'b10));
    tbl.push_back(mk_i(2'b01, 32'h3FC, 32'hFFFF_FFFF));
    tbl.push_back(mk_r(32'h3FC, 3'd2, 32'hCAFE_F00D, 0, 2'b10));

    idx = 0; ap_valid = 0; dp_valid = 0; last_hready = 1; guard = 0; waits = 0;
    while (1) begin
      if (last_hready) begin
        dp_valid = ap_valid;
        waits    = 0;
        if (dp_valid && sb[0].wr) hwdata = sb[0].wdata;
        if (idx < tbl.size()) begin
          drive_ap(tbl[idx]);
          sb.push_back(tbl[idx]);
          ap_valid = 1;
          idx++;
        end else begin
          drive_idle();
          ap_valid = 0;
        end
      end
      if (dp_valid) begin
        cur = sb[0];
        if (!hreadyout) begin
          waits++;
          if (cur.exp_err) begin
            chk($sformatf("err1_hresp@%0h", cur.addr), 32'(hresp), 32'd1);
            chk($sformatf("err1_wen_ren@%0h", cur.addr), {30'b0, wen, ren}, 32'd0);
          end else begin
            chk($sformatf("stall_ren@%0h", cur.addr), 32'(ren), 32'd1);
            chk($sformatf("stall_raddr@%0h", cur.addr), 32'(raddr), 32'(cur.addr[9:0]));
          end
          if (waits > 4) begin
            tests++;
            fails++;
            $display("FAIL wait_bound@%0h: got %0d wait states, expected at most 4", cur.addr, waits);
            break;
          end
        end else begin
          chk($sformatf("hresp@%0h", cur.addr), 32'(hresp), 32'(cur.exp_err));
          chk($sformatf("waits@%0h", cur.addr), 32'(waits), 32'(cur.exp_waits));
          if (cur.wr && cur.trans[1] && !cur.exp_err) begin
            chk($sformatf("wen@%0h", cur.addr), 32'(wen), 32'd1);
            chk($sformatf("wstrb@%0h", cur.addr), 32'(wstrb), 32'(cur.exp_strb));
            chk($sformatf("waddr@%0h", cur.addr), 32'(waddr), 32'(cur.addr[9:0]));
            chk($sformatf("wdata@%0h", cur.addr), wdata, cur.wdata);
          end else begin
            chk($sformatf("no_wen@%0h", cur.addr), 32'(wen), 32'd0);
          end
          if (!cur.wr && cur.trans[1] && !cur.exp_err)
            chk($sformatf("hrdata@%0h", cur.addr), hrdata, cur.exp_rdata);
          else
            chk($sformatf("hrdata_zero@%0h", cur.addr), hrdata, 32'd0);
          if (cur.exp_err) chk($sformatf("err2_ren@%0h", cur.addr), 32'(ren), 32'd0);
          void'(sb.pop_front());
          dp_valid = 0;
        end
      end
      last_hready = hreadyout;
      if (idx >= tbl.size() && !ap_valid && !dp_valid) break;
      guard++;
      if (guard > 1000) begin
        tests++;
        fails++;
        $display("FAIL cycle_budget: got %0d cycles, expected at most 1000", guard);
        break;
      end
      step();
    end

    // reset during a write data phase drops the write
    step();
    op = mk_w(32'h200, 3'd2, 32'hA5A5_A5A5, 4'hF, 2'b10);
    drive_ap(op);
    step();
    hwdata = 32'hA5A5_A5A5;
    reset  = 1'b1;
    drive_idle();
    #1;
    chk("rst_wr_wen", 32'(wen), 32'd0);
    step();
    reset = 1'b0;
    chk("rst_wr_hreadyout", 32'(hreadyout), 32'd1);
    step();
    chk("rst_wr_dropped", mem[8'h80], 32'd0);

    // reset during a stalled read returns to idle
    op = mk_w(32'h204, 3'd2, 32'h5A5A_5A5A, 4'hF, 2'b10);
    drive_ap(op);
    step();
    hwdata = 32'h5A5A_5A5A;
    op = mk_r(32'h204, 3'd2, 32'h0, 1, 2'b10);
    drive_ap(op);
    step();
    chk("stall_entered", 32'(hreadyout), 32'd0);
    reset = 1'b1;
    drive_idle();
    step();
    reset = 1'b0;
    chk("rst_stall_hreadyout", 32'(hreadyout), 32'd1);
    chk("rst_stall_ren", 32'(ren), 32'd0);
    chk("rst_stall_hrdata", hrdata, 32'd0);
    step();
    chk("rst_stall_prior_write", mem[8'h81], 32'h5A5A_5A5A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
